// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: word memory port shared by the copy engine (master) and the memory (slave).
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;
  modport master(output mem_address, mem_wr_en, mem_data_in, input mem_data_out);
  modport slave(input mem_address, mem_wr_en, mem_data_in, output mem_data_out);
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: overlap-safe word block copy, one read cycle then one write cycle per word.
module mem_copy_engine #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  mem_copy_engine_if.master     mem
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr, last_addr, diff, off, step;
  logic [ADDR_WIDTH:0]   len2;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [WORD_WIDTH-1:0] hold;
  logic                  desc, desc_nx;
  // 2*length kept one bit wider than the address so the overlap test never truncates
  assign diff    = dst_addr - src_addr;
  assign len2    = (ADDR_WIDTH+1)'({length, 1'b0});
  assign desc_nx = (dst_addr > src_addr) && ({1'b0, diff} < len2);
  assign off     = len2[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);
  assign step    = desc ? -ADDR_WIDTH'(2) : ADDR_WIDTH'(2);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start ? (length == '0 ? DONE : READ) : IDLE)
             : state == READ  ? WRITE
             : state == WRITE ? (remaining == LEN_WIDTH'(1) ? DONE : READ)
             : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      hold      <= '0;
      desc      <= 1'b0;
      last_addr <= '0;
    end else begin
      last_addr <= mem.mem_address;
      if (state == IDLE && start) begin
        src_ptr   <= desc_nx ? src_addr + off : src_addr;
        dst_ptr   <= desc_nx ? dst_addr + off : dst_addr;
        remaining <= length;
        desc      <= desc_nx;
      end
      if (state == READ) hold <= mem.mem_data_out;
      if (state == WRITE) begin
        src_ptr   <= src_ptr + step;
        dst_ptr   <= dst_ptr + step;
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  assign busy            = state == READ || state == WRITE;
  assign done            = state == DONE;
  assign mem.mem_address = state == READ ? src_ptr : state == WRITE ? dst_ptr : last_addr;
  assign mem.mem_wr_en   = state == WRITE && !reset;
  assign mem.mem_data_in = hold;
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-granular block-copy initiator that drives the 16-bit byte-addressed, big-endian word memory port (combinational read, write on rising clock edge). Given a source address, destination address and word count, it moves `length` 16-bit words by alternating one read cycle and one write cycle per word. It is overlap-safe and chooses ascending or descending order so that overlapping regions are copied correctly. It sits between a control/sequencer block and the memory, and owns the memory port for the duration of a copy.

## Interface
- `WORD_WIDTH`, 16: data word width; fixed to the memory word.
- `ADDR_WIDTH`, 16: byte address width.
- `LEN_WIDTH`, 8: word-count width.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  copy request; sampled only in IDLE.
- `src_addr`  in  ADDR_WIDTH  byte address of first source word; captured on accepted start.
- `dst_addr`  in  ADDR_WIDTH  byte address of first destination word; captured on accepted start.
- `length`  in  LEN_WIDTH  number of words to copy; captured on accepted start.
- `busy`  out  1  high in READ/WRITE states.
- `done`  out  1  one-cycle completion pulse (DONE state).
- `mem_address`  out  ADDR_WIDTH  to memory address.
- `mem_wr_en`  out  1  to memory write enable.
- `mem_data_in`  out  WORD_WIDTH  to memory write data.
- `mem_data_out`  in  WORD_WIDTH  from memory read data, valid in the same cycle as `mem_address`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if `start`, latch `src_addr`, `dst_addr` and `length` into `src_ptr`, `dst_ptr` and `remaining`, then go to READ; if `length`==0, go directly to DONE with no memory access. `start` is ignored in every other state.
- Direction is fixed at start. Descending iff `dst_addr` > `src_addr` (unsigned) and (`dst_addr`−`src_addr`) < 2·`length`, computed without truncating 2·`length`. Otherwise ascending, including dst==src.
- Descending start pointers: `src_ptr`=`src_addr`+2·(`length`−1), `dst_ptr`=`dst_addr`+2·(`length`−1).
- READ: `mem_address`=`src_ptr`, `mem_wr_en`=0. At the edge, capture `mem_data_out` into `hold`, then go to WRITE.
- WRITE: `mem_address`=`dst_ptr`, `mem_data_in`=`hold`, `mem_wr_en`=1. At the edge:
  - step both pointers by +2 (ascending) or −2 (descending);
  - decrement `remaining`;
  - go to DONE if `remaining` was 1, else go to READ.
- DONE: `done`=1, `busy`=0, `mem_wr_en`=0. Go to IDLE unconditionally.
- Pointer arithmetic is modulo 2^ADDR_WIDTH. Wrap past 0xFFFE→0x0000 (or 0x0000→0xFFFE descending) is legal and not flagged.
- Odd addresses are allowed: the memory spans bytes A and A+1; the engine does not align.
- In IDLE and DONE: `mem_address` = last driven value (registered pointer mux), `mem_wr_en`=0.

## Timing
- Reset: state=IDLE; `busy`=0, `done`=0, `mem_wr_en`=0, `mem_address`=0, `mem_data_in`=0, `hold`=0, pointers=0.
- `mem_wr_en` = (state==WRITE) && !`reset`. A reset asserted during a WRITE cycle must suppress that write.
- Reset mid-copy: abort at that edge. Memory keeps the words already written; no completion `done` pulse.
- Latency: `start` sampled at edge E0 → READ of word 0 during E0..E1 → its write commits at E2. Word k commits at E(2k+2). `done` is high during E(2L)..E(2L+1). Next start is accepted at E(2L+2) at the earliest.
- `length`=0: `done` is high during E0..E1, no write.
- Throughput: 2 cycles per word; `busy` high for exactly 2·L cycles.
- Input changes after an accepted start have no effect.

## Test plan
- Forward copy: preload 0x0100..0x0105 = 11 22 33 44 55 66; start with src=0x0100, dst=0x0200, len=3.
  - Required: bytes 0x0200..0x0205 = 11 22 33 44 55 66.
  - Required: `busy` high for 6 cycles; `done` pulses once, 7 cycles after start.
- Overlap, descending: preload same; start with src=0x0100, dst=0x0102, len=3.
  - Required: 0x0102..0x0107 = 11 22 33 44 55 66.
  - Required: first write address 0x0106, then 0x0104, then 0x0102.
- Overlap, ascending: src=0x0102, dst=0x0100, len=2, with 0x0102..0x0105 = AA BB CC DD.
  - Required: 0x0100..0x0103 = AA BB CC DD.
- Zero length and ignored start:
  - len=0: `done` next cycle, `mem_wr_en` never high.
  - Pulse `start` with different operands during `busy`: no change to the in-flight copy and no second `done`.
- Reset mid-op and wrap:
  - Assert `reset` in the 2nd WRITE cycle of a len=4 copy: only word 0 is written, all outputs return to reset values, no `done`.
  - Separately, src=0xFFFC, dst=0x0010, len=3: source words are read from 0xFFFC, 0xFFFE, 0x0000.
